ram_access_controller: RTL and testbench
========================================

Name: ram_access_controller

Overview:
Initiator side of the RAM_32bit_16aline port (address / is_write / in / out). Accepts single-word read/write requests on a valid/ready handshake, sequences the RAM's level-sensitive write strobe with address setup and hold, captures read data after a settle delay, and returns a response on a second valid/ready handshake. Sits between the CPU's load/store stage and the RAM array.

Parameters:
ALINE, 16, RAM address width.
DATA_W, 32, data width.
PULSE_CYCLES, 2, cycles is_write is held high (>=1).
SETTLE_CYCLES, 1, cycles waited after address is applied before read capture (>=1).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request (high only in IDLE)
req_write  input  1  1 = write, 0 = read
req_addr  input  ALINE  word address
req_wdata  input  DATA_W  write data
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  DATA_W  read data (writes: data written)
resp_error  output  1  write-verify mismatch (feature only, else 0)
ram_address  output  ALINE  to RAM address
ram_is_write  output  1  to RAM is_write
ram_in  output  DATA_W  to RAM in
ram_out  input  DATA_W  from RAM out
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, ram_is_write=0, ram_address=0, ram_in=0, counter=0. Interrupted writes are abandoned; is_write drops immediately on reset assertion.
- Request accepted on the rising edge where req_valid && req_ready; req_addr/req_wdata/req_write are latched. Inputs are ignored when not in IDLE.
- States: IDLE, SETUP, STROBE, HOLD, SETTLE, RESP (plus VERIFY with feature).
- IDLE -> SETUP on accept. ram_address/ram_in are driven from latched values starting the cycle after accept and stay stable until RESP is entered.
- SETUP (1 cycle, is_write=0): write -> STROBE; read -> SETTLE.
- STROBE: ram_is_write=1 for exactly PULSE_CYCLES cycles, then HOLD.
- HOLD (1 cycle, is_write=0, address/data unchanged): -> RESP with resp_rdata = latched wdata (no feature).
- SETTLE: count SETTLE_CYCLES cycles; on the last cycle capture ram_out into resp_rdata; -> RESP.
- RESP: resp_valid=1, resp_rdata/resp_error stable until resp_valid && resp_ready, then -> IDLE (resp_valid=0 the next cycle). resp_ready held high in advance is allowed: a 1-cycle RESP then.
- Latency accept -> resp_valid: read = 1+1+SETTLE_CYCLES cycles (3 by default); write = 1+1+PULSE_CYCLES+1 (5 by default).
- ram_is_write is registered and never glitches; it is high only in STROBE.
- Back-to-back: next req_ready is the cycle after the response handshake; no overlap.
- Counter is ceil(log2(max(PULSE_CYCLES, SETTLE_CYCLES))+1) bits wide and resets to 0 on every state entry.

Optional Feature:
Macro RAM_CTRL_WRITE_VERIFY_EN. With it: write path is HOLD -> VERIFY, which waits SETTLE_CYCLES with is_write=0, captures ram_out into resp_rdata, and sets resp_error=1 if ram_out != latched wdata. Write latency increases by SETTLE_CYCLES. Without it: there is no VERIFY state, resp_error is tied to 0, and write resp_rdata = wdata.

Test Plan:
- Write addr 16'hC3BC, data 32'hE5F84AB1, resp_ready=1 -> ram_is_write high exactly 2 cycles with address stable one cycle before and after; resp_valid 5 cycles after accept; resp_rdata=32'hE5F84AB1.
- Read 16'hC3BC after the write -> resp_rdata=32'hE5F84AB1 three cycles after accept; ram_is_write stays 0 throughout.
- Write 16'hB83A=32'h5C8C6A01, then read 16'hC3BC and 16'hB83A -> 32'hE5F84AB1 and 32'h5C8C6A01 respectively (no aliasing).
- Hold resp_ready=0 for 4 cycles in RESP while toggling req_valid -> resp_valid/resp_rdata stable, req_ready=0, no new accept; accept occurs only after the handshake.
- Assert reset during STROBE -> ram_is_write=0 immediately, outputs at reset values; a later read of that address is not checked.
- Feature on: a RAM model that forces bit 0 stuck to 0, write 32'h00000001 -> resp_error=1, resp_rdata=0. Feature off: resp_error stays 0.

Source files
------------

// File: rtl/ram_access_controller.sv
// Single-word initiator for a RAM with a level-sensitive write strobe and an asynchronous read port.
// Optional write read-back check: define RAM_CTRL_WRITE_VERIFY_EN.
module ram_access_controller #(
  parameter int ALINE         = 16,
  parameter int DATA_W        = 32,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ALINE-1:0]  req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output logic [ALINE-1:0]  ram_address,
  output logic              ram_is_write,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
  // once valid is raised the payload is held until that edge, and ready never depends on valid.

  localparam int MAX_CNT = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT) + 1;
  localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_SETTLE = 3'd4,
    S_RESP   = 3'd5,
    S_VERIFY = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic [ALINE-1:0]  r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_is_write;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  logic              r_err;
  logic              w_cap_verify;
`endif

  logic w_accept;
  logic w_is_write_nxt;
  logic w_cap_read;
  logic w_cap_wdata;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = r_write ? S_STROBE : S_SETTLE;
      S_STROBE: if (r_cnt == PULSE_LAST) w_state_nxt = S_HOLD;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
      S_HOLD:   w_state_nxt = S_VERIFY;
      S_VERIFY: if (r_cnt == SETTLE_LAST) w_state_nxt = S_RESP;
`else
      S_HOLD:   w_state_nxt = S_RESP;
`endif
      S_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = S_RESP;
      S_RESP:   if (resp_ready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    req_ready      = (r_state == S_IDLE);
    resp_valid     = (r_state == S_RESP);
    busy           = (r_state != S_IDLE);
    dbg_state      = r_state;
    w_accept       = (r_state == S_IDLE) && req_valid;
    w_is_write_nxt = (w_state_nxt == S_STROBE);
    w_cap_read     = (r_state == S_SETTLE) && (r_cnt == SETTLE_LAST);
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    w_cap_wdata    = 1'b0;
    w_cap_verify   = (r_state == S_VERIFY) && (r_cnt == SETTLE_LAST);
`else
    w_cap_wdata    = (r_state == S_HOLD);
`endif
  end

  // Counter restarts at zero on every state entry and only runs in the timed states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_cnt <= '0;
    end else if (r_state == S_STROBE || r_state == S_SETTLE || r_state == S_VERIFY) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Request latch; address and data stay on the RAM pins until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Strobe is decoded from the next state and registered so it is glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_write <= 1'b0;
    end else begin
      r_is_write <= w_is_write_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_cap_read) begin
      r_rdata <= ram_out;
    end else if (w_cap_wdata) begin
      r_rdata <= r_wdata;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
    end else if (w_cap_verify) begin
      r_rdata <= ram_out;
`endif
    end
  end

`ifdef RAM_CTRL_WRITE_VERIFY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= 1'b0;
    end else if (w_cap_verify) begin
      r_err <= (ram_out != r_wdata);
    end
  end

  assign resp_error = r_err;
`else
  assign resp_error = 1'b0;
`endif

  assign ram_address  = r_addr;
  assign ram_in       = r_wdata;
  assign ram_is_write = r_is_write;
  assign resp_rdata   = r_rdata;

endmodule

// File: tb/tb_ram_access_controller.sv
// Bench for ram_access_controller: RAM model, reference memory, fixed scenarios and random traffic.
module tb_ram_access_controller;
  localparam int ALINE  = 16;
  localparam int DATA_W = 32;
  localparam int PULSE  = 2;
  localparam int SETTLE = 1;
`ifdef RAM_CTRL_WRITE_VERIFY_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif
  localparam int RD_LAT = 2 + SETTLE;
  localparam int WR_LAT = 3 + PULSE + (FEAT ? SETTLE : 0);

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ALINE-1:0]  req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_error;
  logic [ALINE-1:0]  ram_address;
  logic              ram_is_write;
  logic [DATA_W-1:0] ram_in;
  logic [DATA_W-1:0] ram_out;
  logic              busy;
  logic [2:0]        dbg_state;

  ram_access_controller #(
    .ALINE(ALINE), .DATA_W(DATA_W), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .ram_address(ram_address), .ram_is_write(ram_is_write),
    .ram_in(ram_in), .ram_out(ram_out),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: asynchronous read, write while is_write is high at a clock edge; optional stuck bit 0.
  logic [DATA_W-1:0] mem [0:(1<<ALINE)-1];
  bit                stuck0;
  assign ram_out = mem[ram_address];
  always @(posedge clk) begin
    if (ram_is_write) mem[ram_address] <= stuck0 ? (ram_in & ~32'h1) : ram_in;
  end

  // Reference model and scoreboard
  logic [DATA_W-1:0] ref_mem [logic [ALINE-1:0]];
  logic [ALINE-1:0]  addr_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int total;
  int bad;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // One complete transaction with resp_ready held low for 'hold' cycles in RESP.
  task automatic do_txn(input bit wr, input logic [ALINE-1:0] addr,
                        input logic [DATA_W-1:0] wdata, input int hold, input string tag);
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] exp_d;
    bit                exp_e;
    int                exp_lat;
    int                cyc;
    bit                addr_ok;
    bit                pat_ok;
    bit                busy_ok;
    if (wr) begin
      stored  = stuck0 ? (wdata & ~32'h1) : wdata;
      exp_d   = FEAT ? stored : wdata;
      exp_e   = FEAT && (stored != wdata);
      exp_lat = WR_LAT;
      if (!ref_mem.exists(addr)) addr_q.push_back(addr);
      ref_mem[addr] = stored;
    end else begin
      exp_d   = ref_mem[addr];
      exp_e   = 1'b0;
      exp_lat = RD_LAT;
    end
    exp_q.push_back(exp_d);

    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s req_ready_before got=%b exp=1", tag, req_ready);
    end
    req_valid  = 1'b1;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    resp_ready = (hold == 0);

    cyc = 0; addr_ok = 1; pat_ok = 1; busy_ok = 1;
    while (1) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_addr  = ALINE'($urandom);
      req_wdata = $urandom;
      cyc++;
      if (ram_address !== addr || (wr && ram_in !== wdata)) addr_ok = 0;
      if (ram_is_write !== (wr && cyc >= 2 && cyc < 2 + PULSE)) pat_ok = 0;
      if (busy !== 1'b1) busy_ok = 0;
      if (resp_valid === 1'b1 || cyc > 40) break;
    end

    total++;
    if (cyc != exp_lat) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=%0d", tag, cyc, exp_lat);
    end
    total++;
    if (!pat_ok) begin
      bad++;
      $display("FAIL %s strobe_pattern got=broken exp=%0d cycles after setup", tag, wr ? PULSE : 0);
    end
    total++;
    if (!addr_ok) begin
      bad++;
      $display("FAIL %s addr_data_stable got=unstable exp=addr %h", tag, addr);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("FAIL %s busy got=0 exp=1 while in flight", tag);
    end
    exp_d = exp_q.pop_front();
    total++;
    if (resp_rdata !== exp_d) begin
      bad++;
      $display("FAIL %s rdata got=%h exp=%h", tag, resp_rdata, exp_d);
    end
    total++;
    if (resp_error !== exp_e) begin
      bad++;
      $display("FAIL %s resp_error got=%b exp=%b", tag, resp_error, exp_e);
    end

    for (int i = 0; i < hold; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_write = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b1 || resp_rdata !== exp_d || req_ready !== 1'b0 || resp_error !== exp_e) begin
        bad++;
        $display("FAIL %s hold_stable cyc=%0d got valid=%b rdata=%h ready=%b exp valid=1 rdata=%h ready=0",
                 tag, i, resp_valid, resp_rdata, req_ready, exp_d);
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    if (hold != 0) @(negedge clk);
    @(negedge clk);
    total++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s after_handshake got valid=%b ready=%b busy=%b exp valid=0 ready=1 busy=0",
               tag, resp_valid, req_ready, busy);
    end
    resp_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== '0 || resp_error !== 1'b0 ||
        ram_is_write !== 1'b0 || ram_address !== '0 || ram_in !== '0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s reset_values got ready=%b valid=%b rdata=%h err=%b we=%b addr=%h in=%h busy=%b exp 1 0 0 0 0 0 0 0",
               tag, req_ready, resp_valid, resp_rdata, resp_error, ram_is_write, ram_address, ram_in, busy);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    stuck0 = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("reset_release");
  endtask

  task automatic test_write_read;
    do_txn(1'b1, 16'hC3BC, 32'hE5F84AB1, 0, "write_c3bc");
    do_txn(1'b0, 16'hC3BC, '0, 0, "read_c3bc");
  endtask

  task automatic test_no_alias;
    do_txn(1'b1, 16'hB83A, 32'h5C8C6A01, 0, "write_b83a");
    do_txn(1'b0, 16'hC3BC, '0, 0, "alias_read_c3bc");
    do_txn(1'b0, 16'hB83A, '0, 0, "alias_read_b83a");
  endtask

  task automatic test_backpressure;
    do_txn(1'b0, 16'hB83A, '0, 4, "bp_read");
    do_txn(1'b1, 16'h0001, 32'hFFFF_FFFF, 4, "bp_write");
    do_txn(1'b0, 16'h0001, '0, 0, "bp_readback");
  endtask

  task automatic test_verify;
    stuck0 = 1'b1;
    do_txn(1'b1, 16'h0010, 32'h0000_0001, 0, "verify_stuck");
    stuck0 = 1'b0;
    do_txn(1'b0, 16'h0010, '0, 0, "verify_readback");
  endtask

  task automatic test_random;
    logic [ALINE-1:0] a;
    for (int n = 0; n < 40; n++) begin
      if (addr_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        a = ALINE'($urandom);
        do_txn(1'b1, a, $urandom, $urandom_range(0, 3), "rand_write");
      end else begin
        a = addr_q[$urandom_range(0, addr_q.size() - 1)];
        do_txn(1'b0, a, $urandom, $urandom_range(0, 3), "rand_read");
      end
    end
  endtask

  task automatic test_reset_strobe;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h5A5A; req_wdata = 32'h1234_5678;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (ram_is_write !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ram_is_write !== 1'b1) begin
      bad++;
      $display("FAIL strobe_seen got=%b exp=1", ram_is_write);
    end
    #2 reset = 1'b1;
    #1;
    check_reset_values("reset_in_strobe");
    @(negedge clk);
    reset = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    check_reset_values("after_strobe_reset");
    do_txn(1'b0, 16'hC3BC, '0, 0, "read_after_reset");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_no_alias();
    test_backpressure();
    test_verify();
    test_random();
    test_reset_strobe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
